// File: rtl/sensor_scan_receiver.sv
// Scans a bank of sensors through one-hot active-low selects and one shared sense line, then debounces each channel into stable registered levels.
// Optional water-level plausibility check: define SENSOR_CONFLICT_CHECK_EN.
module sensor_scan_receiver #(
  parameter int CHANNELS      = 6,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE      = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sense_in,
  output logic [CHANNELS-1:0] sensor_select,
  output logic [CHANNELS-1:0] sensors,
  output logic                sensors_valid,
  output logic                sensor_changed,
  output logic                level_conflict
);

  localparam int LAST_PHASE = SETTLE_CYCLES + 1;
  localparam int PW = $clog2(LAST_PHASE + 1);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);

  localparam logic [PW-1:0] SAMPLE_PH = PW'(SETTLE_CYCLES);
  localparam logic [PW-1:0] LAST_PH   = PW'(LAST_PHASE);
  localparam logic [CW-1:0] LAST_CH   = CW'(CHANNELS - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE);

  logic [PW-1:0]                phase_q, phase_d;
  logic [CW-1:0]                ch_q, ch_d;
  logic [CHANNELS-1:0]          cand_q, cand_d;
  logic [CHANNELS-1:0][DW-1:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0]          acc_q, acc_d;
  logic [CHANNELS-1:0]          sensors_q, sensors_d;
  logic                         valid_q, valid_d;
  logic                         changed_q, changed_d;
  logic                         conflict_q, conflict_d;
  logic                         accept;
  logic [CHANNELS-1:0]          next_sens;

  always_comb begin
    phase_d    = phase_q;
    ch_d       = ch_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sensors_d  = sensors_q;
    conflict_d = conflict_q;
    accept     = 1'b0;
    next_sens  = sensors_q;

    if (phase_q == LAST_PH) begin
      phase_d = '0;
      ch_d    = (ch_q == LAST_CH) ? '0 : ch_q + CW'(1);
    end else begin
      phase_d = phase_q + PW'(1);
    end

    if (phase_q == SAMPLE_PH) begin
      if (sense_in == cand_q[ch_q]) begin
        if (cnt_q[ch_q] != DEB_MAX) cnt_d[ch_q] = cnt_q[ch_q] + DW'(1);
      end else begin
        cand_d[ch_q] = sense_in;
        cnt_d[ch_q]  = DW'(1);
      end
      accept = (cnt_d[ch_q] == DEB_MAX);
    end

    if (accept) begin
      acc_d[ch_q]     = 1'b1;
      next_sens[ch_q] = cand_d[ch_q];
`ifdef SENSOR_CONFLICT_CHECK_EN
      // Water probes must read as a filled column from the bottom up.
      if (ch_q < CW'(3)) begin
        conflict_d = !(next_sens[2:0] inside {3'b000, 3'b001, 3'b011, 3'b111});
        if (conflict_d) next_sens[2:0] = sensors_q[2:0];
      end
`endif
      sensors_d = next_sens;
    end

    changed_d = (sensors_d != sensors_q);
    valid_d   = &acc_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q    <= '0;
      ch_q       <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      sensors_q  <= '0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      ch_q       <= ch_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      sensors_q  <= sensors_d;
      valid_q    <= valid_d;
      changed_q  <= changed_d;
      conflict_q <= conflict_d;
    end
  end

  // Select is decoded from registered slot state; the last phase of each slot blanks.
  always_comb begin
    sensor_select = '1;
    if (!reset && phase_q <= SAMPLE_PH) sensor_select[ch_q] = 1'b0;
  end

  assign sensors        = sensors_q;
  assign sensors_valid  = valid_q;
  assign sensor_changed = changed_q;
  assign level_conflict = conflict_q;

endmodule
